// File: rtl/data_mem_stage.sv
// Memory-access stage: word-addressed data memory with configurable wait
// states, upstream stall, and the MEM/WB pipeline register.
module data_mem_stage #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_in_dm,
    input  logic        mem_write_in_dm,
    input  logic        reg_write_in_dm,
    input  logic        mem_to_reg_in_dm,
    input  logic        branch_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] write_data_in,
    input  logic [4:0]  rd_in,
    output logic        stall_flag,
    output logic        branch_out_ex_dm,
    output logic [31:0] read_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  rd_out,
    output logic        reg_write_out,
    output logic        mem_to_reg_out,
    output logic        misalign_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = 3;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Captured request, held while BUSY
    logic [31:0] cap_alu_q, cap_alu_d;
    logic [31:0] cap_wdata_q, cap_wdata_d;
    logic [4:0]  cap_rd_q, cap_rd_d;
    logic        cap_rw_q, cap_rw_d;
    logic        cap_m2r_q, cap_m2r_d;
    logic        cap_mr_q, cap_mr_d;
    logic        cap_mw_q, cap_mw_d;

    // Registered outputs
    logic        stall_q, stall_d;
    logic        branch_q, branch_d;
    logic        misalign_q, misalign_d;
    logic [31:0] read_data_q, read_data_d;
    logic [31:0] alu_q, alu_d;
    logic [4:0]  rd_q, rd_d;
    logic        rw_q, rw_d;
    logic        m2r_q, m2r_d;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] acc_idx_c;
    logic [31:0]   mem_rdata_c;
    logic          mem_we_c;
    logic [31:0]   mem_wdata_c;

    // Access index: live input while IDLE, captured address while BUSY
    always_comb begin
        acc_idx_c   = (state_q == BUSY) ? cap_alu_q[AW+1:2] : alu_result_in[AW+1:2];
        mem_rdata_c = mem[acc_idx_c];
    end

    // Next-state, capture, memory-write and MEM/WB update logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cap_alu_d   = cap_alu_q;
        cap_wdata_d = cap_wdata_q;
        cap_rd_d    = cap_rd_q;
        cap_rw_d    = cap_rw_q;
        cap_m2r_d   = cap_m2r_q;
        cap_mr_d    = cap_mr_q;
        cap_mw_d    = cap_mw_q;
        stall_d     = stall_q;
        branch_d    = branch_q;
        misalign_d  = 1'b0;
        read_data_d = read_data_q;
        alu_d       = alu_q;
        rd_d        = rd_q;
        rw_d        = rw_q;
        m2r_d       = m2r_q;
        mem_we_c    = 1'b0;
        mem_wdata_c = write_data_in;

        case (state_q)
            IDLE: begin
                branch_d = branch_in;
                if (mem_read_in_dm || mem_write_in_dm) begin
                    if (alu_result_in[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        rw_d       = 1'b0;
                        m2r_d      = 1'b0;
                    end else if (WAIT_STATES == 0) begin
                        mem_we_c    = mem_write_in_dm;
                        mem_wdata_c = write_data_in;
                        if (mem_read_in_dm) begin
                            read_data_d = mem_rdata_c;
                        end
                        alu_d = alu_result_in;
                        rd_d  = rd_in;
                        rw_d  = reg_write_in_dm;
                        m2r_d = mem_to_reg_in_dm;
                    end else begin
                        cap_alu_d   = alu_result_in;
                        cap_wdata_d = write_data_in;
                        cap_rd_d    = rd_in;
                        cap_rw_d    = reg_write_in_dm;
                        cap_m2r_d   = mem_to_reg_in_dm;
                        cap_mr_d    = mem_read_in_dm;
                        cap_mw_d    = mem_write_in_dm;
                        cnt_d       = CW'(WAIT_STATES);
                        state_d     = BUSY;
                        stall_d     = 1'b1;
                        rw_d        = 1'b0;
                        m2r_d       = 1'b0;
                    end
                end else begin
                    alu_d = alu_result_in;
                    rd_d  = rd_in;
                    rw_d  = reg_write_in_dm;
                    m2r_d = mem_to_reg_in_dm;
                end
            end
            BUSY: begin
                branch_d = 1'b0;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    mem_we_c    = cap_mw_q;
                    mem_wdata_c = cap_wdata_q;
                    if (cap_mr_q) begin
                        read_data_d = mem_rdata_c;
                    end
                    alu_d   = cap_alu_q;
                    rd_d    = cap_rd_q;
                    rw_d    = cap_rw_q;
                    m2r_d   = cap_m2r_q;
                    state_d = IDLE;
                    stall_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, capture and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cap_alu_q   <= '0;
            cap_wdata_q <= '0;
            cap_rd_q    <= '0;
            cap_rw_q    <= 1'b0;
            cap_m2r_q   <= 1'b0;
            cap_mr_q    <= 1'b0;
            cap_mw_q    <= 1'b0;
            stall_q     <= 1'b0;
            branch_q    <= 1'b0;
            misalign_q  <= 1'b0;
            read_data_q <= '0;
            alu_q       <= '0;
            rd_q        <= '0;
            rw_q        <= 1'b0;
            m2r_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cap_alu_q   <= cap_alu_d;
            cap_wdata_q <= cap_wdata_d;
            cap_rd_q    <= cap_rd_d;
            cap_rw_q    <= cap_rw_d;
            cap_m2r_q   <= cap_m2r_d;
            cap_mr_q    <= cap_mr_d;
            cap_mw_q    <= cap_mw_d;
            stall_q     <= stall_d;
            branch_q    <= branch_d;
            misalign_q  <= misalign_d;
            read_data_q <= read_data_d;
            alu_q       <= alu_d;
            rd_q        <= rd_d;
            rw_q        <= rw_d;
            m2r_q       <= m2r_d;
        end
    end

    // Data memory array; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[acc_idx_c] <= mem_wdata_c;
        end
    end

    assign stall_flag       = stall_q;
    assign branch_out_ex_dm = branch_q;
    assign misalign_err     = misalign_q;
    assign read_data_out    = read_data_q;
    assign alu_result_out   = alu_q;
    assign rd_out           = rd_q;
    assign reg_write_out    = rw_q;
    assign mem_to_reg_out   = m2r_q;

endmodule

// File: tb/tb_data_mem_stage.sv
// Scoreboard bench for data_mem_stage: instance a uses 1 wait state,
// instance b uses 3; both share the upstream inputs.
module tb_data_mem_stage;

    logic        clk;
    logic        rst_a, rst_b;
    logic        mr, mw, rw, m2r, br;
    logic [31:0] alu, wd;
    logic [4:0]  rd;

    logic        a_stall, a_br, a_rw, a_m2r, a_mis;
    logic [31:0] a_rdata, a_alu;
    logic [4:0]  a_rd;
    logic        b_stall, b_br, b_rw, b_m2r, b_mis;
    logic [31:0] b_rdata, b_alu;
    logic [4:0]  b_rd;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    localparam int S_RDATA = 0, S_ALU = 1, S_RD = 2, S_RW = 3, S_M2R = 4,
                   S_STALL = 5, S_MIS = 6, S_BR = 7,
                   S_B_RDATA = 8, S_B_RW = 9, S_B_M2R = 10, S_B_STALL = 11, S_B_RD = 12;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];

    data_mem_stage #(.DEPTH_WORDS(256), .WAIT_STATES(1)) u_dut_a (
        .clk(clk), .reset(rst_a),
        .mem_read_in_dm(mr), .mem_write_in_dm(mw), .reg_write_in_dm(rw),
        .mem_to_reg_in_dm(m2r), .branch_in(br), .alu_result_in(alu),
        .write_data_in(wd), .rd_in(rd),
        .stall_flag(a_stall), .branch_out_ex_dm(a_br), .read_data_out(a_rdata),
        .alu_result_out(a_alu), .rd_out(a_rd), .reg_write_out(a_rw),
        .mem_to_reg_out(a_m2r), .misalign_err(a_mis)
    );

    data_mem_stage #(.DEPTH_WORDS(256), .WAIT_STATES(3)) u_dut_b (
        .clk(clk), .reset(rst_b),
        .mem_read_in_dm(mr), .mem_write_in_dm(mw), .reg_write_in_dm(rw),
        .mem_to_reg_in_dm(m2r), .branch_in(br), .alu_result_in(alu),
        .write_data_in(wd), .rd_in(rd),
        .stall_flag(b_stall), .branch_out_ex_dm(b_br), .read_data_out(b_rdata),
        .alu_result_out(b_alu), .rd_out(b_rd), .reg_write_out(b_rw),
        .mem_to_reg_out(b_m2r), .misalign_err(b_mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_tests++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act_v, exp_v, cyc);
        end
    endtask

    function automatic logic [31:0] act(input int sel);
        case (sel)
            S_RDATA:   return a_rdata;
            S_ALU:     return a_alu;
            S_RD:      return 32'(a_rd);
            S_RW:      return 32'(a_rw);
            S_M2R:     return 32'(a_m2r);
            S_STALL:   return 32'(a_stall);
            S_MIS:     return 32'(a_mis);
            S_BR:      return 32'(a_br);
            S_B_RDATA: return b_rdata;
            S_B_RW:    return 32'(b_rw);
            S_B_M2R:   return 32'(b_m2r);
            S_B_STALL: return 32'(b_stall);
            S_B_RD:    return 32'(b_rd);
            default:   return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Expect value v on output sel after k more rising edges
    function automatic void exp_at(input int k, input int sel, input logic [31:0] v, input string name);
        sb.push_back('{cyc + k, sel, v, name});
    endfunction

    // Monitor: compare every due scoreboard entry on the falling edge
    always @(negedge clk) begin : monitor
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc < cyc) begin
                chk({sb[i].name, "_missed"}, 32'(sb[i].cyc), 32'(cyc));
                sb.delete(i);
            end else if (sb[i].cyc == cyc) begin
                chk(sb[i].name, act(sb[i].sel), sb[i].exp);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic issue(input logic i_mr, input logic i_mw, input logic i_rw, input logic i_m2r,
                         input logic i_br, input logic [31:0] i_alu, input logic [31:0] i_wd,
                         input logic [4:0] i_rd, input int waits);
        mr = i_mr; mw = i_mw; rw = i_rw; m2r = i_m2r; br = i_br;
        alu = i_alu; wd = i_wd; rd = i_rd;
        repeat (waits) @(negedge clk);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        mr = 0; mw = 0; rw = 0; m2r = 0; br = 0; alu = '0; wd = '0; rd = '0;
        rst_a = 1; rst_b = 1;
        #1 rst_a = 0; rst_b = 0;
        #2;
        chk("rst_a_stall", 32'(a_stall), 0);
        chk("rst_a_br",    32'(a_br), 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_a_alu",   a_alu, 0);
        chk("rst_a_rd",    32'(a_rd), 0);
        chk("rst_a_rw",    32'(a_rw), 0);
        chk("rst_a_m2r",   32'(a_m2r), 0);
        chk("rst_a_mis",   32'(a_mis), 0);
        repeat (2) @(negedge clk);
        rst_a = 1; rst_b = 1;
        @(negedge clk);

        // Store then load back, one wait state
        exp_at(1, S_STALL, 1, "st_stall_hi");
        exp_at(1, S_RW, 0, "st_bubble_rw");
        exp_at(2, S_STALL, 0, "st_stall_lo");
        issue(0, 1, 0, 0, 0, 32'h10, 32'hDEAD_BEEF, 5'd0, 2);
        exp_at(1, S_STALL, 1, "ld_stall_hi");
        exp_at(1, S_RW, 0, "ld_bubble_rw");
        exp_at(1, S_M2R, 0, "ld_bubble_m2r");
        exp_at(2, S_STALL, 0, "ld_stall_lo");
        exp_at(2, S_RDATA, 32'hDEAD_BEEF, "ld_rdata");
        exp_at(2, S_RD, 5, "ld_rd");
        exp_at(2, S_RW, 1, "ld_rw");
        exp_at(2, S_M2R, 1, "ld_m2r");
        exp_at(2, S_ALU, 32'h10, "ld_alu");
        issue(1, 0, 1, 1, 0, 32'h10, 32'h0, 5'd5, 2);

        // Non-memory pass-through, read data holds
        exp_at(1, S_ALU, 32'h777, "nop_alu");
        exp_at(1, S_RD, 3, "nop_rd");
        exp_at(1, S_RW, 1, "nop_rw");
        exp_at(1, S_STALL, 0, "nop_no_stall");
        exp_at(1, S_RDATA, 32'hDEAD_BEEF, "nop_rdata_hold");
        issue(0, 0, 1, 0, 0, 32'h777, 32'h0, 5'd3, 1);

        // Address wrap: 0x400 aliases word 0
        issue(0, 1, 0, 0, 0, 32'h400, 32'h1234, 5'd0, 2);
        exp_at(2, S_RDATA, 32'h1234, "wrap_rdata");
        issue(1, 0, 1, 1, 0, 32'h000, 32'h0, 5'd7, 2);

        // Misaligned store is dropped
        exp_at(1, S_MIS, 1, "mis_pulse");
        exp_at(1, S_STALL, 0, "mis_no_stall");
        exp_at(1, S_RW, 0, "mis_bubble_rw");
        issue(0, 1, 1, 0, 0, 32'h13, 32'h1111_1111, 5'd1, 1);
        exp_at(1, S_MIS, 0, "mis_pulse_end");
        exp_at(2, S_RDATA, 32'hDEAD_BEEF, "mis_prior_data");
        issue(1, 0, 1, 1, 0, 32'h10, 32'h0, 5'd2, 2);

        // Both strobes: store with read-before-write
        issue(0, 1, 0, 0, 0, 32'h20, 32'hA, 5'd0, 2);
        exp_at(2, S_RDATA, 32'hA, "rmw_old");
        issue(1, 1, 0, 0, 0, 32'h20, 32'hB, 5'd0, 2);
        exp_at(2, S_RDATA, 32'hB, "rmw_new");
        issue(1, 0, 1, 1, 0, 32'h20, 32'h0, 5'd1, 2);

        // Branch pass-through and squash while BUSY
        exp_at(1, S_BR, 1, "br_hi");
        issue(0, 0, 0, 0, 1, 32'h0, 32'h0, 5'd0, 1);
        exp_at(1, S_BR, 0, "br_lo");
        issue(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 1);
        exp_at(1, S_BR, 1, "br_idle_edge");
        exp_at(2, S_BR, 0, "br_busy_edge");
        issue(1, 0, 1, 1, 1, 32'h20, 32'h0, 5'd1, 2);

        // Let instance b settle into IDLE
        issue(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 5);

        // Three wait states on instance b
        issue(0, 1, 0, 0, 0, 32'hC, 32'h77, 5'd0, 4);
        exp_at(1, S_B_STALL, 1, "b_stall_1");
        exp_at(2, S_B_STALL, 1, "b_stall_2");
        exp_at(3, S_B_STALL, 1, "b_stall_3");
        exp_at(4, S_B_STALL, 0, "b_stall_end");
        exp_at(1, S_B_RW, 0, "b_bubble_rw_1");
        exp_at(3, S_B_RW, 0, "b_bubble_rw_3");
        exp_at(3, S_B_M2R, 0, "b_bubble_m2r_3");
        exp_at(4, S_B_RDATA, 32'h77, "b_ld_rdata");
        exp_at(4, S_B_RD, 9, "b_ld_rd");
        exp_at(4, S_B_RW, 1, "b_ld_rw");
        issue(1, 0, 1, 1, 0, 32'hC, 32'h0, 5'd9, 4);

        // Reset in the middle of a pending store
        issue(0, 1, 0, 0, 0, 32'h8, 32'h0, 5'd0, 4);
        issue(0, 1, 0, 0, 0, 32'h8, 32'h55, 5'd0, 2);
        #2 rst_b = 0;
        #2;
        chk("b_rst_stall", 32'(b_stall), 0);
        chk("b_rst_rdata", b_rdata, 0);
        chk("b_rst_alu",   b_alu, 0);
        chk("b_rst_rd",    32'(b_rd), 0);
        chk("b_rst_rw",    32'(b_rw), 0);
        chk("b_rst_m2r",   32'(b_m2r), 0);
        chk("b_rst_br",    32'(b_br), 0);
        chk("b_rst_mis",   32'(b_mis), 0);
        mr = 0; mw = 0; wd = '0;
        @(negedge clk);
        rst_b = 1;
        exp_at(4, S_B_RDATA, 32'h0, "b_rst_no_store");
        exp_at(4, S_B_RW, 1, "b_rst_ld_rw");
        issue(1, 0, 1, 1, 0, 32'h8, 32'h0, 5'd4, 4);

        issue(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 6);
        chk("sb_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
